// File: rtl/sparse_pkg.sv
// Shared state encoding and default sizing for the sparse frame encoder.
package sparse_pkg;

    localparam int default_col_length         = 8;
    localparam int default_word_length        = 8;
    localparam int default_double_word_length = 16;
    localparam int default_image_size         = 7;
    localparam int default_max_nnz            = 52;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/sparse_entry_buf.sv
// Indexed (value, column, row) entry storage with a frame-start clear that zero-fills
// every slot while still accepting the first write of the new frame.
module sparse_entry_buf
    import sparse_pkg::*;
#(
    parameter int col_length         = default_col_length,
    parameter int word_length        = default_word_length,
    parameter int double_word_length = default_double_word_length,
    parameter int max_nnz            = default_max_nnz
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              wr_en,
    input  logic [double_word_length-1:0]     wr_idx,
    input  logic [word_length-1:0]            wr_value,
    input  logic [col_length-1:0]             wr_col,
    input  logic [col_length-1:0]             wr_row,
    output logic [max_nnz*word_length-1:0]    feature_value,
    output logic [max_nnz*col_length-1:0]     feature_cols,
    output logic [max_nnz*col_length-1:0]     feature_rows
);

    generate
        for (genvar gi = 0; gi < max_nnz; gi++) begin : g_entry
            logic [word_length-1:0] value_reg;
            logic [col_length-1:0]  col_reg;
            logic [col_length-1:0]  row_reg;
            logic                   hit;

            assign hit = wr_en && (wr_idx == double_word_length'(gi));

            // A write wins over clear so the first pixel of a frame lands in slot 0.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    value_reg <= '0;
                    col_reg   <= '0;
                    row_reg   <= '0;
                end else if (hit) begin
                    value_reg <= wr_value;
                    col_reg   <= wr_col;
                    row_reg   <= wr_row;
                end else if (clear) begin
                    value_reg <= '0;
                    col_reg   <= '0;
                    row_reg   <= '0;
                end
            end

            assign feature_value[(gi+1)*word_length-1 -: word_length] = value_reg;
            assign feature_cols[(gi+1)*col_length-1 -: col_length]    = col_reg;
            assign feature_rows[(gi+1)*col_length-1 -: col_length]    = row_reg;
        end
    endgenerate

endmodule

// File: rtl/sparse_encoder.sv
// Dense-to-sparse frame encoder: raster pixels in, (value, col, row) list out per frame.
// Optional magnitude threshold input when SPARSE_ENC_THRESH_EN is defined.
module sparse_encoder
    import sparse_pkg::*;
#(
    parameter int col_length         = default_col_length,
    parameter int word_length        = default_word_length,
    parameter int double_word_length = default_double_word_length,
    parameter int image_size         = default_image_size,
    parameter int max_nnz            = default_max_nnz
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic signed [word_length-1:0]     pixel_in,
`ifdef SPARSE_ENC_THRESH_EN
    input  logic [word_length-1:0]            threshold,
`endif
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [double_word_length-1:0]     feature_valid_num,
    output logic [max_nnz*word_length-1:0]    feature_value,
    output logic [max_nnz*col_length-1:0]     feature_cols,
    output logic [max_nnz*col_length-1:0]     feature_rows,
    output logic                              overflow
);

    localparam logic [col_length-1:0]         last_idx = col_length'(image_size - 1);
    localparam logic [double_word_length-1:0] cap      = double_word_length'(max_nnz);

    state_t                        state_reg;
    logic                          in_ready_reg;
    logic                          out_valid_reg;
    logic                          overflow_reg;
    logic [col_length-1:0]         row_reg;
    logic [col_length-1:0]         col_reg;
    logic [double_word_length-1:0] count_reg;

    logic                          accept;
    logic                          start;
    logic                          is_nz;
    logic                          room;
    logic                          last_pixel;
    logic                          wr_en;
    logic [double_word_length-1:0] count_base;
    logic                          overflow_base;

`ifdef SPARSE_ENC_THRESH_EN
    // One extra bit so the most negative pixel has a representable magnitude.
    logic signed [word_length:0] pixel_ext;
    logic [word_length:0]        pixel_mag;

    assign pixel_ext = {pixel_in[word_length-1], pixel_in};
    assign pixel_mag = pixel_in[word_length-1] ? $unsigned(-pixel_ext) : $unsigned(pixel_ext);
    assign is_nz     = pixel_mag > {1'b0, threshold};
`else
    assign is_nz = |pixel_in;
`endif

    assign accept     = in_valid && in_ready_reg;
    assign start      = accept && (state_reg == IDLE);
    assign last_pixel = (row_reg == last_idx) && (col_reg == last_idx);

    // On the first pixel of a frame the previous results are discarded in the same cycle.
    assign count_base    = start ? '0 : count_reg;
    assign overflow_base = start ? 1'b0 : overflow_reg;
    assign room          = count_base < cap;
    assign wr_en         = accept && is_nz && room;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            row_reg       <= '0;
            col_reg       <= '0;
            count_reg     <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE, COLLECT: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        if (last_pixel) begin
                            row_reg <= '0;
                            col_reg <= '0;
                        end else if (col_reg == last_idx) begin
                            row_reg <= row_reg + 1'b1;
                            col_reg <= '0;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end

                        count_reg    <= wr_en ? count_base + 1'b1 : count_base;
                        overflow_reg <= overflow_base | (is_nz & ~room);

                        if (last_pixel) begin
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= COLLECT;
                        end
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    sparse_entry_buf #(
        .col_length         (col_length),
        .word_length        (word_length),
        .double_word_length (double_word_length),
        .max_nnz            (max_nnz)
    ) u_entry_buf (
        .clk           (clk),
        .rst           (rst),
        .clear         (start),
        .wr_en         (wr_en),
        .wr_idx        (count_base),
        .wr_value      (pixel_in),
        .wr_col        (col_reg),
        .wr_row        (row_reg),
        .feature_value (feature_value),
        .feature_cols  (feature_cols),
        .feature_rows  (feature_rows)
    );

    assign in_ready          = in_ready_reg;
    assign out_valid         = out_valid_reg;
    assign feature_valid_num = count_reg;
    assign overflow          = overflow_reg;

endmodule

// File: tb/tb_sparse_encoder.sv
// Directed bench for sparse_encoder: default instance plus a max_nnz=40 instance on shared stimulus.
module tb_sparse_encoder;

    localparam int NNZ = 52;
    localparam int CAP = 40;
    localparam int N   = 49;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid;
    logic signed [7:0] pixel_in;
`ifdef SPARSE_ENC_THRESH_EN
    logic [7:0]        threshold;
`endif

    logic              in_ready, out_valid, overflow;
    logic [15:0]       fvn;
    logic [NNZ*8-1:0]  fv, fc, fr;

    logic              c_in_ready, c_out_valid, c_overflow;
    logic [15:0]       c_fvn;
    logic [CAP*8-1:0]  c_fv, c_fc, c_fr;

    sparse_encoder dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .pixel_in          (pixel_in),
`ifdef SPARSE_ENC_THRESH_EN
        .threshold         (threshold),
`endif
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .feature_valid_num (fvn),
        .feature_value     (fv),
        .feature_cols      (fc),
        .feature_rows      (fr),
        .overflow          (overflow)
    );

    sparse_encoder #(.max_nnz(CAP)) dut_cap (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .pixel_in          (pixel_in),
`ifdef SPARSE_ENC_THRESH_EN
        .threshold         (threshold),
`endif
        .in_ready          (c_in_ready),
        .out_valid         (c_out_valid),
        .feature_valid_num (c_fvn),
        .feature_value     (c_fv),
        .feature_cols      (c_fc),
        .feature_rows      (c_fr),
        .overflow          (c_overflow)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int c_pulses = 0;
    int p0, cp0;
    logic signed [7:0] frame [N];

    always @(posedge clk) begin
        if (out_valid)   pulses++;
        if (c_out_valid) c_pulses++;
    end

    function automatic logic [7:0] val(input int k);  return fv[k*8 +: 8];   endfunction
    function automatic logic [7:0] col(input int k);  return fc[k*8 +: 8];   endfunction
    function automatic logic [7:0] row(input int k);  return fr[k*8 +: 8];   endfunction
    function automatic logic [7:0] cval(input int k); return c_fv[k*8 +: 8]; endfunction
    function automatic logic [7:0] ccol(input int k); return c_fc[k*8 +: 8]; endfunction
    function automatic logic [7:0] crow(input int k); return c_fr[k*8 +: 8]; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) frame[i] = 8'sd0;
    endtask

    // Streams frame[0..n-1]; returns on the negedge after the last transfer.
    task automatic send_frame(input int n, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 400) begin
            @(negedge clk);
            guard++;
            if (gaps && (guard % 4 == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                pixel_in = frame[i];
                if (in_ready) i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("sent_count", i, n);
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        pixel_in = 8'sd0;
`ifdef SPARSE_ENC_THRESH_EN
        threshold = 8'd0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fvn", fvn, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_entries", {|fv, |fc, |fr}, 0);
        chk("rst_cap_ready", c_in_ready, 0);

        // Pixel offered across reset release must not be taken.
        in_valid = 1'b1;
        pixel_in = 8'sd5;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        chk("no_early_accept", fvn, 0);
        in_valid = 1'b0;
        $display("step: reset done");

        // All-zero frame
        clear_frame();
        send_frame(N, 1'b0);
        chk("zero_out_valid", out_valid, 1);
        chk("zero_in_ready_done", in_ready, 0);
        chk("zero_fvn", fvn, 0);
        chk("zero_entries", {|fv, |fc, |fr}, 0);
        chk("zero_overflow", overflow, 0);
        @(negedge clk);
        chk("zero_pulse_end", out_valid, 0);
        chk("zero_ready_idle", in_ready, 1);
        $display("step: zero frame");

        // Single nonzero at raster 10, with input gaps; pixel offered during DONE
        clear_frame();
        frame[10] = 8'sd5;
        send_frame(N, 1'b1);
        in_valid = 1'b1;
        pixel_in = 8'sd77;
        chk("single_out_valid", out_valid, 1);
        chk("single_fvn", fvn, 1);
        chk("single_val", val(0), 8'd5);
        chk("single_row", row(0), 8'd1);
        chk("single_col", col(0), 8'd3);
        chk("single_e1_zero", val(1), 8'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_drop_fvn", fvn, 1);
        chk("done_drop_val", val(0), 8'd5);
        $display("step: single nonzero frame");

        // All -1: fills 49 of 52, overflows the 40-entry instance
        for (int i = 0; i < N; i++) frame[i] = -8'sd1;
        send_frame(N, 1'b0);
        chk("neg_fvn", fvn, 49);
        chk("neg_e48_val", val(48), 8'hFF);
        chk("neg_e48_row", row(48), 8'd6);
        chk("neg_e48_col", col(48), 8'd6);
        chk("neg_tail_zero", {|fv[NNZ*8-1:N*8], |fc[NNZ*8-1:N*8], |fr[NNZ*8-1:N*8]}, 0);
        chk("neg_overflow", overflow, 0);
        chk("neg_cap_fvn", c_fvn, CAP);
        chk("neg_cap_overflow", c_overflow, 1);
        $display("step: all -1 frame");

        // Ramp 1..49: entry k carries pixel k
        for (int i = 0; i < N; i++) frame[i] = 8'(i + 1);
        send_frame(N, 1'b0);
        chk("ramp_fvn", fvn, 49);
        chk("ramp_e20_val", val(20), 8'd21);
        chk("ramp_e20_row", row(20), 8'd2);
        chk("ramp_e20_col", col(20), 8'd6);
        chk("ramp_cap_fvn", c_fvn, CAP);
        chk("ramp_cap_overflow", c_overflow, 1);
        chk("ramp_cap_e39_val", cval(39), 8'd40);
        chk("ramp_cap_e39_row", crow(39), 8'd5);
        chk("ramp_cap_e39_col", ccol(39), 8'd4);
        repeat (5) @(negedge clk);
        chk("hold_cap_e39_val", cval(39), 8'd40);
        chk("hold_cap_fvn", c_fvn, CAP);
        $display("step: ramp frame");

        // Corners, with the previous overflow cleared on the new frame
        clear_frame();
        frame[0]  = 8'sd7;
        frame[48] = -8'sd128;
        send_frame(N, 1'b0);
        chk("corner_fvn", fvn, 2);
        chk("corner_e0", {val(0), row(0), col(0)}, {8'd7, 8'd0, 8'd0});
        chk("corner_e1", {val(1), row(1), col(1)}, {8'h80, 8'd6, 8'd6});
        chk("corner_e2_cleared", val(2), 8'd0);
        chk("corner_cap_fvn", c_fvn, 2);
        chk("corner_cap_overflow", c_overflow, 0);
        repeat (2) @(negedge clk);
        p0  = pulses;
        cp0 = c_pulses;
        $display("step: corner frame");

        // Abort a frame after 20 pixels
        for (int i = 0; i < N; i++) frame[i] = 8'sd9;
        send_frame(20, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_fvn", fvn, 0);
        chk("abort_entries", |fv, 0);
        chk("abort_in_ready", in_ready, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_pulse", pulses, p0);
        chk("abort_cap_no_pulse", c_pulses, cp0);
        clear_frame();
        frame[47] = -8'sd2;
        send_frame(N, 1'b0);
        chk("after_abort_fvn", fvn, 1);
        chk("after_abort_e0", {val(0), row(0), col(0)}, {8'hFE, 8'd6, 8'd5});
        repeat (2) @(negedge clk);
        chk("after_abort_pulse", pulses, p0 + 1);
        $display("step: aborted frame then fresh frame");

`ifdef SPARSE_ENC_THRESH_EN
        threshold = 8'd3;
        clear_frame();
        frame[0] = 8'sd3;
        frame[1] = -8'sd3;
        frame[2] = 8'sd4;
        frame[3] = -8'sd128;
        send_frame(N, 1'b0);
        chk("thr_fvn", fvn, 2);
        chk("thr_e0", {val(0), col(0)}, {8'd4, 8'd2});
        chk("thr_e1", {val(1), col(1)}, {8'h80, 8'd3});
        threshold = 8'd0;
        $display("step: threshold frame");
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
